// File: rtl/mux_rr_scheduler.sv
// Round-robin owner scheduler for a shared 8:1 single-bit mux. Grants are registered, bounded
// by HOLD_MAX under contention, and always separated by one idle gap cycle.
module mux_rr_scheduler #(
  parameter int unsigned HOLD_MAX = 4,
  parameter int unsigned CNT_W    = $clog2(HOLD_MAX) + 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       sel_valid,
  output logic       busy
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         last_q;
  logic [2:0]         sel_q;
  logic [7:0]         grant_q;
  logic               sel_valid_q;
  logic               busy_q;

  logic [2:0]         win;
  logic [2:0]         idx;
  logic               found;
  logic               owner_req;
  logic               other_req;
  logic               at_max;

  // Circular priority scan starting just after the last granted index.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = last_q + k[2:0];
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign owner_req = |(req & grant_q);
  assign other_req = |(req & ~grant_q);
  assign at_max    = (cnt_q == CNT_W'(HOLD_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      last_q      <= 3'd7;
      sel_q       <= 3'd0;
      grant_q     <= 8'h00;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            state_q     <= StGrant;
            grant_q     <= 8'd1 << win;
            sel_q       <= win;
            sel_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            cnt_q       <= '0;
            last_q      <= win;
          end
        end
        StGrant: begin
          if (!owner_req || (at_max && other_req)) begin
            // Selects are left untouched so the mux input never changes while leaving.
            state_q     <= StIdle;
            grant_q     <= 8'h00;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
          end else if (!at_max) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign grant     = grant_q;
  assign s0        = sel_q[0];
  assign s1        = sel_q[1];
  assign s2        = sel_q[2];
  assign sel_valid = sel_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed and randomized checks of mux_rr_scheduler against an ownership-history model,
// including an 8:1 mux built in the bench to confirm the selected data reaches out.
module tb_mux_rr_scheduler;

  localparam int HOLD_MAX = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] grant;
  logic       s0, s1, s2, sel_valid, busy;
  logic [7:0] d = 8'h00;
  logic       out_mux;

  int checks = 0;
  int errors = 0;

  // Model: owner index (-1 when none), cycles owned so far, last winner, held select.
  int m_owner, m_held, m_last, m_sel;

  mux_rr_scheduler #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .grant     (grant),
    .s0        (s0),
    .s1        (s1),
    .s2        (s2),
    .sel_valid (sel_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign out_mux = d[{s2, s1, s0}];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic int scan(input logic [7:0] r, input int last);
    for (int k = 1; k <= 8; k++) begin
      if (r[(last + k) % 8]) return (last + k) % 8;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_owner = -1;
    m_held  = 0;
    m_last  = 7;
    m_sel   = 0;
  endtask

  task automatic model_step(input logic [7:0] r);
    if (m_owner < 0) begin
      if (r != 8'h00) begin
        m_owner = scan(r, m_last);
        m_last  = m_owner;
        m_sel   = m_owner;
        m_held  = 1;
      end
    end else begin
      logic [7:0] others;
      others = r & ~(8'd1 << m_owner);
      if (!r[m_owner] || (m_held >= HOLD_MAX && others != 8'h00)) m_owner = -1;
      else m_held++;
    end
  endtask

  task automatic check_model();
    logic [7:0] eg;
    logic       ev;
    eg = (m_owner < 0) ? 8'h00 : (8'd1 << m_owner);
    ev = (m_owner >= 0);
    chk("grant", grant, eg);
    chk("sel", 8'({s2, s1, s0}), 8'(m_sel));
    chk("sel_valid", 8'(sel_valid), 8'(ev));
    chk("busy", 8'(busy), 8'(ev));
    chk("out", 8'(out_mux), 8'(d[m_sel]));
    chk("onehot0", 8'($onehot0(grant)), 8'd1);
  endtask

  task automatic step();
    logic [7:0] r;
    r = req;
    @(posedge clk);
    #1;
    model_step(r);
    check_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 8'h00);
    chk("rst_valid", 8'({sel_valid, busy}), 8'h00);
    rst_n = 1'b1;
  endtask

  initial begin
    m_reset();

    // Reset and idle
    req = 8'h00;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_grant", grant, 8'h00);
      chk("idle_sel", 8'({s2, s1, s0}), 8'h00);
    end

    // Single requester, uncontested hold well past HOLD_MAX
    req = 8'h08;
    d   = 8'h00;
    step();
    chk("single_grant", grant, 8'h08);
    chk("single_sel", 8'({s2, s1, s0}), 8'h03);
    chk("single_out0", 8'(out_mux), 8'h00);
    d = 8'h08;
    #1;
    chk("single_out1", 8'(out_mux), 8'h01);
    for (int i = 0; i < 19; i++) step();
    chk("single_hold", grant, 8'h08);
    req = 8'h00;
    step();
    chk("single_rel", grant, 8'h00);
    chk("single_selhold", 8'({s2, s1, s0}), 8'h03);
    d = 8'h00;

    // Round robin with every line requesting
    do_reset();
    req = 8'hFF;
    for (int t = 0; t < 9; t++) begin
      for (int j = 0; j < HOLD_MAX; j++) begin
        step();
        chk("rr_grant", grant, 8'd1 << (t % 8));
        chk("rr_sel", 8'({s2, s1, s0}), 8'(t % 8));
      end
      step();
      chk("rr_gap", grant, 8'h00);
      chk("rr_gapsel", 8'({s2, s1, s0}), 8'(t % 8));
    end
    req = 8'h00;
    step();

    // Preemption fairness: 5 owns, 2 arrives late
    req = 8'h20;
    for (int i = 0; i < 10; i++) step();
    chk("pre_own5", grant, 8'h20);
    req = 8'h24;
    step();
    chk("pre_gap", grant, 8'h00);
    step();
    chk("pre_grant2", grant, 8'h04);
    for (int i = 0; i < 20 && grant !== 8'h20; i++) step();
    chk("pre_regrant5", grant, 8'h20);
    req = 8'h00;
    step();
    step();

    // Owner 6 drops while 1 rises
    do_reset();
    req = 8'h40;
    step();
    chk("sim_own6", grant, 8'h40);
    step();
    step();
    req = 8'h02;
    step();
    chk("sim_gap", grant, 8'h00);
    chk("sim_gapsel", 8'({s2, s1, s0}), 8'h06);
    step();
    chk("sim_grant1", grant, 8'h02);
    chk("sim_sel1", 8'({s2, s1, s0}), 8'h01);
    req = 8'h00;
    step();

    // Asynchronous reset in the middle of a grant
    do_reset();
    req = 8'h10;
    step();
    chk("mid_own4", grant, 8'h10);
    step();
    #3;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("mid_grant", grant, 8'h00);
    chk("mid_valid", 8'({sel_valid, busy}), 8'h00);
    chk("mid_sel", 8'({s2, s1, s0}), 8'h00);
    req = 8'h11;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("mid_win0", grant, 8'h01);
    req = 8'h00;
    step();
    step();

    // Randomized traffic with slowly toggling request lines
    do_reset();
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      end
      d = 8'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_scheduler.md
Name: mux_rr_scheduler

Overview:
- Round-robin scheduler that shares one 8:1 single-bit mux (selects s2,s1,s0; data d0..d7; output out) between 8 requesters.
- Requester i owns mux data input di.
- The block drives s2..s0 to pass the granted requester's data to out, and returns a one-hot grant.
- Bounded hold time prevents starvation; a mandatory idle gap cycle between grants keeps select changes clean.

Parameters:
- HOLD_MAX, 4: maximum consecutive grant cycles while another requester is waiting. Legal range is 1..256.
- CNT_W, $clog2(HOLD_MAX)+1: hold-counter width. Derived; do not override.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  8  req[i] high while requester i wants the mux. Requester holds it until done.
- grant  output  8  one-hot grant. All zero when no owner.
- s0  output  1  mux select bit 0.
- s1  output  1  mux select bit 1.
- s2  output  1  mux select bit 2 (MSB). {s2,s1,s0} equals the granted index.
- sel_valid  output  1  high when s2..s0 select a granted requester, so the mux out is meaningful.
- busy  output  1  high in GRANT state.

Behaviour:
- Reset (rst_n low, asynchronous, any state, including mid-grant):
  - grant=0, {s2,s1,s0}=000, sel_valid=0, busy=0.
  - state=IDLE, hold counter=0, last-pointer=7, so requester 0 has first priority.
- All outputs are registered. No combinational path from req to any output.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, pick winner w = the first set req bit scanning circularly from last+1 (wraps 7->0).
  - Next cycle: state=GRANT, grant=1<<w, {s2,s1,s0}=w, sel_valid=1, busy=1, counter=0, last=w.
  - Latency is 1 cycle from req sampled high in IDLE to grant high.
- State GRANT, evaluated each cycle with current owner c:
  - Release when req[c]==0: next cycle is IDLE, grant=0, sel_valid=0, busy=0.
  - Preempt when counter==HOLD_MAX-1 and (req & ~(1<<c))!=0: same transition as release.
  - Otherwise stay in GRANT:
    - counter increments, saturating at HOLD_MAX-1.
    - If counter is at HOLD_MAX-1 and no other req is pending, the grant is kept and the counter holds. Ownership is unlimited while uncontested.
- Gap cycle:
  - Every exit from GRANT spends at least one cycle in IDLE with sel_valid=0.
  - Arbitration happens in that IDLE cycle, so back-to-back grants are separated by exactly one gap cycle.
- Select hold in IDLE:
  - {s2,s1,s0} keeps the last granted value. They change only on entry to GRANT.
  - There is never a select change while sel_valid=1.
- Pointer:
  - last updates only on grant.
  - A preempted owner goes to lowest priority. It re-requests by keeping req high and is served after the others in circular order.
- Simultaneous events:
  - A req rising in the same cycle as a release or preempt is seen by the IDLE arbitration.
  - A requester dropping req in IDLE is not granted.
  - A req glitch on an idle line during GRANT has no effect unless it is present when the counter reaches HOLD_MAX-1.
- Invariants:
  - grant is zero or one-hot.
  - grant != 0 exactly when sel_valid=1 and busy=1.
  - Whenever sel_valid=1, grant[{s2,s1,s0}]=1.
- HOLD_MAX=1: any contention forces release after 1 grant cycle.

Test Plan:
- Reset/idle:
  - Stimulus: assert rst_n=0, release it, keep req=0 for 10 cycles.
  - Required: grant=00, s2..s0=000, sel_valid=0, busy=0 throughout.
- Single requester:
  - Stimulus: req=0x08 from cycle 0 to 20, then 0.
  - Required: the cycle after req goes high, grant=0x08 and s2..s0=011. Grant holds past HOLD_MAX (uncontested). One cycle after req drops, grant=0 and s2..s0 stay 011.
  - Check: drive d3 0->1 while granted; out follows 0->1.
- Round robin:
  - Stimulus: req=0xFF held, HOLD_MAX=4.
  - Required: grants go 0,1,2,...,7,0, each exactly 4 cycles with a 1-cycle gap. s2..s0 track the grant index. The sequence wraps 7->0.
- Preemption fairness:
  - Stimulus: req[5] high alone; after 10 cycles raise req[2].
  - Required: requester 5 is released when its counter next reaches HOLD_MAX-1. After one gap cycle, grant=0x04. Then requester 5 is regranted after requester 2's turn.
- Simultaneous release/request:
  - Stimulus: owner 6 drops req in the same cycle req[1] rises, with last=6.
  - Required: one gap cycle, then grant=0x02, s2..s0=001.
- Reset mid-grant:
  - Stimulus: rst_n low while grant=0x10, asynchronous to clk.
  - Required: grant=0 and sel_valid=0 immediately. After release with req=0x11, requester 0 wins (pointer reset to 7).
